// File: rtl/hazard_scb_pkg.sv
// Shared definitions for the hazard scoreboard: entry layout, encodings and
// the entry-width helper used by the top and the match comparator.
package hazard_scb_pkg;

  // Layout reference for the default 5-bit register index. Modules that take
  // REG_AW as a parameter declare a local struct with the same field order.
  localparam int REG_AW_DEF = 5;

  typedef struct packed {
    logic                  valid;
    logic                  is_load;
    logic [REG_AW_DEF-1:0] dst;
  } scb_entry_t;

  // Forwarding select value meaning "no older producer matches".
  localparam int FWD_NONE = 0;

  // Architectural register 0 is hard-wired and never creates a hazard.
  localparam int REG_ZERO = 0;

  // Width of one {valid, is_load, dst} entry.
  function automatic int entry_w(input int reg_aw);
    return reg_aw + 2;
  endfunction

endpackage

// File: rtl/hazard_scb_match.sv
// Priority comparator: returns the lowest-numbered (youngest) valid stage
// whose destination equals the source register, or FWD_NONE.
// Purely combinational; one instance per decode source operand.
module hazard_scb_match
  import hazard_scb_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int SEL_W  = 2
) (
  input  logic [DEPTH*(REG_AW+2)-1:0] slots_i,
  input  logic [REG_AW-1:0]           src_i,
  output logic [SEL_W-1:0]            sel_o
);

  localparam int EW = entry_w(REG_AW);

  // Walk from oldest to youngest so the youngest match is written last.
  always_comb begin
    sel_o = SEL_W'(FWD_NONE);
    for (int k = DEPTH; k >= 1; k--) begin
      if (slots_i[k*EW-1] &&
          (slots_i[(k-1)*EW +: REG_AW] == src_i) &&
          (src_i != REG_AW'(REG_ZERO))) begin
        sel_o = SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Destination-register history for the last DEPTH issued instructions with
// youngest-match forwarding selects and a load-use stall request.
// Optional load-use stall counter enabled by defining HAZARD_SCB_STATS_EN.
// Handshake: none; adv=1 shifts the history one stage at the rising edge,
// flush=1 clears it (and drops the incoming instruction), otherwise it holds.
module hazard_scoreboard
  import hazard_scb_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,   // legal 1..7, and 2**SEL_W must exceed DEPTH
  parameter int SEL_W  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        adv,
  input  logic                        in_valid,
  input  logic                        in_wen,
  input  logic [REG_AW-1:0]           in_dst,
  input  logic                        in_is_load,
  input  logic                        flush,
  input  logic [REG_AW-1:0]           src_a,
  input  logic [REG_AW-1:0]           src_b,
`ifdef HAZARD_SCB_STATS_EN
  input  logic                        stats_clr,
  output logic [31:0]                 stall_cnt,
`endif
  output logic [SEL_W-1:0]            fwd_sel_a,
  output logic [SEL_W-1:0]            fwd_sel_b,
  output logic                        load_use_stall,
  output logic [DEPTH*(REG_AW+2)-1:0] slot_bus
);

  localparam int EW = entry_w(REG_AW);

  typedef struct packed {
    logic              valid;
    logic              is_load;
    logic [REG_AW-1:0] dst;
  } entry_t;

  // Index 0 is stage 1 (youngest).
  entry_t stage_q [DEPTH];
  entry_t stage_d [DEPTH];
  entry_t new_entry;

  // Only a real register write to a non-zero register becomes a valid entry;
  // everything else enters as an all-zero bubble.
  always_comb begin
    new_entry = '0;
    if (in_valid && in_wen && (in_dst != REG_AW'(REG_ZERO))) begin
      new_entry.valid   = 1'b1;
      new_entry.is_load = in_is_load;
      new_entry.dst     = in_dst;
    end
  end

  // Next history: flush beats advance, advance beats hold.
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      for (int k = 0; k < DEPTH; k++) stage_d[k] = '0;
    end else if (adv) begin
      stage_d[0] = new_entry;
      for (int k = 1; k < DEPTH; k++) stage_d[k] = stage_q[k-1];
    end
  end

  // History register with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // Debug view: stage k occupies bits [k*EW-1 -: EW].
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    assign slot_bus[g*EW +: EW] = stage_q[g];
  end

  hazard_scb_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_a (
    .slots_i (slot_bus),
    .src_i   (src_a),
    .sel_o   (fwd_sel_a)
  );

  hazard_scb_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_b (
    .slots_i (slot_bus),
    .src_i   (src_b),
    .sel_o   (fwd_sel_b)
  );

  // A load one stage ahead cannot forward in time; older loads forward normally.
  assign load_use_stall = stage_q[0].valid && stage_q[0].is_load &&
                          (((stage_q[0].dst == src_a) && (src_a != REG_AW'(REG_ZERO))) ||
                           ((stage_q[0].dst == src_b) && (src_b != REG_AW'(REG_ZERO))));

`ifdef HAZARD_SCB_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // Saturating stall counter; clear wins over increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stats_clr) begin
      stall_cnt_d = '0;
    end else if (load_use_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Counter register with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
